// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver. Start bit, DATA_WIDTH data bits LSB
// first, optional parity, one stop bit. Majority-of-three sampling around the
// bit centre; registered Data_Valid / Par_err / Stp_err strobes.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchroniser on RX_IN.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_err,
    output logic                  Stp_err
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    rx_s;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    samp0;
    logic                    samp1;
    logic                    sampled_bit;
    logic                    par_flag;
    logic                    dv_nxt;
    logic                    pe_nxt;
    logic                    se_nxt;

    logic [PRESCALE_W-1:0]   half_c;
    logic [PRESCALE_W-1:0]   e_s0_c;
    logic [PRESCALE_W-1:0]   e_s1_c;
    logic [PRESCALE_W-1:0]   e_chk_c;
    logic [PRESCALE_W-1:0]   e_last_c;
    logic                    last_edge_c;
    logic                    last_bit_c;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser, idles high so reset never looks like a start bit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RX_IN};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_IN;
`endif

    // Sampling instants derived from the prescale latched for this frame
    assign half_c      = prescale_q >> 1;
    assign e_s0_c      = half_c - PRESCALE_W'(2);
    assign e_s1_c      = half_c - PRESCALE_W'(1);
    assign e_chk_c     = half_c + PRESCALE_W'(1);
    assign e_last_c    = prescale_q - PRESCALE_W'(1);
    assign last_edge_c = (edge_cnt == e_last_c);
    assign last_bit_c  = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt = state;
        dv_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        se_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if ((edge_cnt == e_chk_c) && sampled_bit) state_nxt = IDLE;
                else if (last_edge_c)                     state_nxt = DATA;
            end
            DATA: begin
                if (last_edge_c && last_bit_c) state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (last_edge_c) state_nxt = STOP;
            end
            STOP: begin
                if (last_edge_c) begin
                    state_nxt = IDLE;
                    se_nxt    = !sampled_bit;
                    pe_nxt    = par_flag;
                    dv_nxt    = sampled_bit && !par_flag;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Edge/bit counters and per-frame configuration latch
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            if (!rx_s) begin
                edge_cnt   <= PRESCALE_W'(1);
                prescale_q <= PRESCALE;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
            end else begin
                edge_cnt <= '0;
            end
        end else begin
            if (state_nxt == IDLE || last_edge_c) edge_cnt <= '0;
            else                                  edge_cnt <= edge_cnt + PRESCALE_W'(1);
            if (state == DATA && last_edge_c) begin
                if (last_bit_c) bit_cnt <= '0;
                else            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    // Majority-of-three sampler around the bit centre
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp0       <= 1'b1;
            samp1       <= 1'b1;
            sampled_bit <= 1'b1;
        end else if (state != IDLE) begin
            if (edge_cnt == e_s0_c) samp0 <= rx_s;
            if (edge_cnt == e_s1_c) samp1 <= rx_s;
            if (edge_cnt == half_c)
                sampled_bit <= (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
        end
    end

    // Data shift register and parity error flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_reg <= '0;
            par_flag  <= 1'b0;
        end else begin
            if (state == IDLE) par_flag <= 1'b0;
            if (state == DATA && last_edge_c)
                shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
            if (state == PARITY && last_edge_c)
                par_flag <= (sampled_bit != ((^shift_reg) ^ par_typ_q));
        end
    end

    // Registered outputs; P_DATA only moves on a clean frame
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
        end else begin
            Data_Valid <= dv_nxt;
            Par_err    <= pe_nxt;
            Stp_err    <= se_nxt;
            if (dv_nxt) P_DATA <= shift_reg;
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receiver counterpart of the team's UART transmitter.
- Oversamples the serial line RX_IN at CLK/PRESCALE per bit and deserialises one frame: start, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
- Presents P_DATA with a one-cycle Data_Valid strobe and flags parity/stop errors.
- Sits in the system's UART path, feeding the register/control logic on the CLK domain.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame
- PRESCALE_W, 6, width of the PRESCALE input and of the internal edge counter

Ports:
- CLK  input  1  oversampling clock
- RST  input  1  asynchronous, active-high reset
- RX_IN  input  1  serial line, idle high
- PRESCALE  input  PRESCALE_W  CLK cycles per bit. Must be even and >=6; 8, 16 and 32 are the supported operating values.
- PAR_EN  input  1  1 = parity bit present after data
- PAR_TYP  input  1  0 = even, 1 = odd
- P_DATA  output  DATA_WIDTH  last correctly received byte
- Data_Valid  output  1  one-cycle strobe, P_DATA updated
- Par_err  output  1  one-cycle strobe, parity mismatch
- Stp_err  output  1  one-cycle strobe, stop bit sampled low

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset mid-frame aborts the frame; no strobes fire.
- PRESCALE, PAR_EN and PAR_TYP are latched on start detection and held for the whole frame. Mid-frame changes have no effect until the next frame.
- Edge counter edge_cnt counts 0..P-1 per bit (P = latched PRESCALE). bit_cnt counts bits within the frame.
- Sampling: the bit value is the majority of RX_IN at edge_cnt = P/2-2, P/2-1 and P/2. It is evaluated at P/2 and used from P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when RX_IN is 0, go to START with edge_cnt = 1; the detection cycle counts as edge 0.
- START: at edge P/2+1, if the sampled bit is 1 (glitch), return to IDLE with no strobes. Otherwise continue; at edge P-1, go to DATA.
- DATA: the sampled bit shifts into the shift register LSB first. After DATA_WIDTH bits (edge P-1 of the last bit), go to PARITY if PAR_EN, else STOP.
- PARITY: the expected bit is XOR of the data bits, inverted when PAR_TYP = 1. A mismatch sets an internal error flag. At edge P-1, go to STOP.
- STOP: at edge P-1, evaluate the frame:
  - Sampled stop = 0: Stp_err = 1 for one cycle.
  - Stop = 1 with parity error: Par_err = 1 for one cycle.
  - Stop = 1 without parity error: P_DATA <= shift register and Data_Valid = 1 for one cycle.
  - Stop = 0 with a parity error raises both Par_err and Stp_err.
  - Strobes are registered and appear the cycle after edge P-1 of the stop bit.
- After STOP, return to IDLE. If RX_IN is already 0 in that strobe cycle, that cycle is edge 0 of the next start bit, so back-to-back frames receive with no lost cycles.
- P_DATA holds its value except on a valid frame. Errored frames never modify P_DATA.
- Frame length: P*(DATA_WIDTH+2+PAR_EN) cycles from the start falling edge to the strobe, plus 1 cycle.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchroniser (reset value 1) before the FSM and sampler. All detection and sampling instants, and the strobe, shift 2 cycles later relative to the raw pin.
- Undefined: RX_IN is used directly and must already be synchronous to CLK.

Test Plan:
- PRESCALE = 8, PAR_EN = 0: send 0xA5 -> Data_Valid single pulse, P_DATA = 0xA5, Par_err = Stp_err = 0. Strobe at 80 cycles + 1 after the start edge.
- PRESCALE = 16, PAR_EN = 1, PAR_TYP = 0: send 0x3C with parity 0 -> P_DATA = 0x3C, Data_Valid pulse. Resend with parity 1 -> Par_err pulse, no Data_Valid, P_DATA stays 0x3C.
- PRESCALE = 32, PAR_TYP = 1: send 0x01 with stop bit 0 -> Stp_err pulse, no Data_Valid, FSM back to IDLE, next frame 0x7E received correctly.
- Glitch: RX_IN low for 2 CLK at PRESCALE = 16 -> no strobes, FSM returns to IDLE by edge P/2+1.
- Back-to-back frames 0x11, 0x22, 0x33 with zero idle at PRESCALE = 8 -> three Data_Valid pulses 80 cycles apart with the correct P_DATA. Also flip single samples at the P/2-2 position -> majority still yields correct data.
- Assert RST in the middle of DATA bit 4 -> outputs 0, no strobe. The following clean frame 0xC3 is received correctly.
